// File: rtl/decryption_pipe.sv
// decryption_pipe: 5-stage pipelined decryptor with valid/ready whole-pipe stall and delivered-word counter.
// Optional DECRYPTION_SELFCHECK_EN adds check_err, a sticky re-encryption mismatch flag.
module decryption_pipe #(
    parameter int N     = 8,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     key,
    input  logic [N-1:0]     e_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     d_data,
    output logic [CNT_W-1:0] out_count
`ifdef DECRYPTION_SELFCHECK_EN
    ,
    output logic             check_err
`endif
);

    function automatic logic [N-1:0] rot_right5(input logic [N-1:0] y);
        return {y[4:0], y[N-1:5]};
    endfunction

    function automatic logic [N-1:0] rot_left5(input logic [N-1:0] y);
        return {y[N-6:0], y[N-1:N-5]};
    endfunction

    function automatic logic [N-1:0] bit_rev(input logic [N-1:0] y);
        logic [N-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < N; i++) begin
            r[i] = y[N-1-i];
        end
        return r;
    endfunction

    logic [4:0]   vld;
    logic [N-1:0] s1_data, s2_data, s3_data, s4_data, s5_data;
    logic [N-1:0] s1_key, s2_key, s3_key, s4_key;
    logic         advance;

    assign advance   = out_ready | ~out_valid;
    assign in_ready  = advance;
    assign out_valid = vld[4];
    assign d_data    = s5_data;

    // Whole-pipe stall: bubbles shift along with valid words, nothing collapses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld     <= '0;
            s1_data <= '0;
            s2_data <= '0;
            s3_data <= '0;
            s4_data <= '0;
            s5_data <= '0;
            s1_key  <= '0;
            s2_key  <= '0;
            s3_key  <= '0;
            s4_key  <= '0;
        end else if (advance) begin
            vld     <= {vld[3:0], in_valid};
            s1_data <= rot_right5(e_data);
            s2_data <= bit_rev(s1_data);
            s3_data <= ~s2_data;
            s4_data <= rot_left5(s3_data);
            s5_data <= s4_data ^ s4_key;
            s1_key  <= key;
            s2_key  <= s1_key;
            s3_key  <= s2_key;
            s4_key  <= s3_key;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_count <= '0;
        end else if (out_valid && out_ready) begin
            out_count <= out_count + CNT_W'(1);
        end
    end

`ifdef DECRYPTION_SELFCHECK_EN
    function automatic logic [N-1:0] encrypt(input logic [N-1:0] p, input logic [N-1:0] k);
        return rot_left5(bit_rev(~rot_right5(p ^ k)));
    endfunction

    logic [N-1:0] s1_ct, s2_ct, s3_ct, s4_ct, s5_ct;
    logic [N-1:0] s5_key;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_ct  <= '0;
            s2_ct  <= '0;
            s3_ct  <= '0;
            s4_ct  <= '0;
            s5_ct  <= '0;
            s5_key <= '0;
        end else if (advance) begin
            s1_ct  <= e_data;
            s2_ct  <= s1_ct;
            s3_ct  <= s2_ct;
            s4_ct  <= s3_ct;
            s5_ct  <= s4_ct;
            s5_key <= s4_key;
        end
    end

    // Re-encrypting the delivered word must reproduce the ciphertext it came from.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            check_err <= 1'b0;
        end else if (out_valid && out_ready && (encrypt(s5_data, s5_key) != s5_ct)) begin
            check_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_decryption_pipe.sv
// Randomized self-checking bench for decryption_pipe against a round-trip reference model.
// A second instance with CNT_W=4 exercises counter wrap; DECRYPTION_SELFCHECK_EN enables check_err tests.
module tb_decryption_pipe;

    logic       clock = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] key;
    logic [7:0] e_data;

    logic        in_ready, out_valid;
    logic [7:0]  d_data;
    logic [15:0] out_count;
    logic        in_ready4, out_valid4;
    logic [7:0]  d_data4;
    logic [3:0]  out_count4;
`ifdef DECRYPTION_SELFCHECK_EN
    logic        check_err, check_err4;
`endif

    always #5 clock = ~clock;

    decryption_pipe #(.N(8), .CNT_W(16)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .key(key), .e_data(e_data), .out_valid(out_valid), .out_ready(out_ready),
        .d_data(d_data), .out_count(out_count)
`ifdef DECRYPTION_SELFCHECK_EN
        , .check_err(check_err)
`endif
    );

    decryption_pipe #(.N(8), .CNT_W(4)) dut4 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
        .key(key), .e_data(e_data), .out_valid(out_valid4), .out_ready(out_ready),
        .d_data(d_data4), .out_count(out_count4)
`ifdef DECRYPTION_SELFCHECK_EN
        , .check_err(check_err4)
`endif
    );

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_q[$];
    int         model_cnt = 0;
    bit         skip_data = 1'b0;
    bit         hold_pend = 1'b0;
    logic [7:0] hold_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference cipher on plain integers in 0..255.
    function automatic int rotl5(input int x);
        return (x * 32 + x / 8) % 256;
    endfunction

    function automatic int rotr5(input int x);
        return (x * 8 + x / 32) % 256;
    endfunction

    function automatic int reverse8(input int x);
        int r = 0;
        for (int i = 0; i < 8; i++) r = r * 2 + ((x >> i) & 1);
        return r;
    endfunction

    function automatic logic [7:0] encrypt(input int p, input int k);
        int t;
        t = (p ^ k) & 255;
        t = rotr5(t);
        t = 255 - t;
        t = reverse8(t);
        t = rotl5(t);
        return 8'(t);
    endfunction

    // Output monitor: scoreboard, counter tracking and stall stability.
    always @(negedge clock) begin
        logic [7:0] e;
        if (reset) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", 32'(d_data), 32'(hold_data));
            end
            hold_pend = out_valid && !out_ready;
            hold_data = d_data;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("stale_word", 32'(out_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    if (!skip_data) check("d_data", 32'(d_data), 32'(e));
                end
                check("out_count", 32'(out_count), 32'(model_cnt % 65536));
                check("out_count4", 32'(out_count4), 32'(model_cnt % 16));
                model_cnt++;
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic push(input logic [7:0] k, input logic [7:0] e, input logic [7:0] exp, output int tries);
        logic acc;
        acc   = 1'b0;
        tries = 0;
        in_valid = 1'b1;
        key      = k;
        e_data   = e;
        while (!acc && tries < 50) begin
            @(negedge clock);
            acc = in_ready;
            tries++;
            @(posedge clock);
            #1;
        end
        check("push_accept", 32'(acc), 32'd1);
        if (acc) exp_q.push_back(exp);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        reset     = 1'b1;
        exp_q.delete();
        model_cnt = 0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    initial begin
        int         tries, lat, w, base;
        logic [7:0] p, k, tmp;

        reset = 1'b1; in_valid = 1'b0; key = '0; e_data = '0; out_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_d_data", 32'(d_data), 32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("idle_in_ready", 32'(in_ready), 32'd1);

        // Single word: latency counted in falling edges after the accepting edge.
        push(8'hA5, 8'h99, 8'h3C, tries);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        check("latency", 32'(lat), 32'd5);
        check("single_data", 32'(d_data), 32'h3C);
        @(posedge clock);
        #1;
        check("single_count", 32'(out_count), 32'd1);

        push(8'h00, 8'hFF, 8'h00, tries);
        push(8'hFF, 8'hFF, 8'hFF, tries);
        idle(8);

        // Back-to-back stream, a distinct key per word.
        do_reset();
        base = $urandom_range(0, 255);
        for (int i = 0; i < 20; i++) begin
            p = 8'($urandom);
            k = 8'((base + i * 29) % 256);
            push(k, encrypt(p, k), p, tries);
            check("stream_first_try", 32'(tries), 32'd1);
        end
        in_valid = 1'b0;
        w = 0;
        while (exp_q.size() != 0 && w < 20) begin
            @(negedge clock);
            #1;
            w++;
        end
        check("stream_drain_cycles", 32'(w), 32'd5);
        @(posedge clock);
        #1;
        check("stream_count", 32'(out_count), 32'd20);

        // Backpressure: fill the pipe, then hold the consumer off for 7 cycles.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            p = 8'($urandom);
            k = 8'($urandom);
            push(k, encrypt(p, k), p, tries);
        end
        p = 8'($urandom);
        k = 8'($urandom);
        in_valid = 1'b1;
        key      = k;
        e_data   = encrypt(p, k);
        for (int i = 0; i < 7; i++) begin
            @(negedge clock);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            @(posedge clock);
            #1;
        end
        out_ready = 1'b1;
        push(k, encrypt(p, k), p, tries);
        in_valid = 1'b0;
        w = 0;
        while (exp_q.size() != 0 && w < 20) begin
            @(negedge clock);
            #1;
            w++;
        end
        check("bp_drained", 32'(exp_q.size()), 32'd0);
        idle(2);

        // Reset with three words in flight.
        for (int i = 0; i < 3; i++) begin
            p = 8'($urandom);
            k = 8'($urandom);
            push(k, encrypt(p, k), p, tries);
        end
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_count", 32'(out_count), 32'd0);
        check("midrst_d_data", 32'(d_data), 32'd0);
        exp_q.delete();
        model_cnt = 0;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("no_stale", 32'(out_valid), 32'd0);
        end
        @(posedge clock);
        #1;

        // Counter wrap on the 4-bit instance.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            p = 8'($urandom);
            k = 8'($urandom);
            push(k, encrypt(p, k), p, tries);
        end
        idle(8);
        check("wrap_count4", 32'(out_count4), 32'd1);
        check("count16", 32'(out_count), 32'd17);

`ifdef DECRYPTION_SELFCHECK_EN
        check("check_err_clean", 32'(check_err), 32'd0);
        check("check_err4_clean", 32'(check_err4), 32'd0);
        p = 8'($urandom);
        k = 8'($urandom);
        push(k, encrypt(p, k), p, tries);
        idle(2);
        skip_data = 1'b1;
        tmp = dut.s3_data ^ 8'h01;
        force dut.s3_data = tmp;
        @(posedge clock);
        #1;
        release dut.s3_data;
        idle(6);
        check("check_err_set", 32'(check_err), 32'd1);
        check("check_err4_clear", 32'(check_err4), 32'd0);
        skip_data = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
